// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_sync_param: AFULL_THRESH must lie in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_param: AEMPTY_THRESH must lie in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] dout_q;
  logic [CW-1:0]    count_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // Accept decisions use the registered flags, so a full FIFO still pops and an
  // empty FIFO still pushes when both requests arrive together.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; unread contents are unreachable after rst anyway.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout_q       <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout_q <= mem[rd_ptr];
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      almost_full  <= (count_nxt >= AFULL_C);
      empty        <= (count_nxt == '0);
      almost_empty <= (count_nxt <= AEMPTY_C);
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; dout_q keeps the last popped word for the empty case.
  assign data_out = empty ? dout_q : mem[rd_ptr];
`else
  assign data_out = dout_q;
`endif

endmodule
